sync_phase_tracker: RTL

- Downstream consumer of the single-cycle `sync_pulse` from the synchroniser stage (double-flop plus rising-edge detect).
- Maintains the local transducer period counter, modulo `PERIOD_CYCLES`, that all phase generators on the board key off.
- Realigns that counter on every sync, measures alignment error, and runs a lock/watchdog FSM reporting sync health to control logic.

---
 rtl/sync_pkg.sv | 19 +
 rtl/sync_watchdog.sv | 41 ++++
 rtl/sync_phase_tracker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared types and helpers for the sync phase tracker.
//   sync_lock_state_t : lock/watchdog FSM states
//   DEF_PERIOD_CYCLES : default transducer period in clk cycles (50 MHz / 40 kHz)
//   cnt_width()       : bit width needed to hold 0..n-1 (minimum 1)
package sync_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } sync_lock_state_t;

   localparam int DEF_PERIOD_CYCLES = 1250;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_watchdog.sv
// Saturating sync-loss watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   kick     : clears the count (a sync was received)
//   arm      : expiry is only reported while armed
//   expired  : one-cycle pulse on the cycle the count is about to reach TIMEOUT
module sync_watchdog
   import sync_pkg::*;
#(
   parameter int TIMEOUT = 2500
) (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   input  logic arm,
   output logic expired
);

   localparam int             W     = cnt_width(TIMEOUT + 1);
   localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);
   localparam logic [W-1:0]   PRE   = W'(TIMEOUT - 1);

   logic [W-1:0] count_r;

   // Cycles since the last kick, held at TIMEOUT once reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (kick) begin
         count_r <= '0;
      end else if (count_r != LIMIT) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Flags the edge on which the count reaches TIMEOUT; saturation makes it
   // fire once per loss event, and a simultaneous kick suppresses it.
   assign expired = arm && !kick && (count_r == PRE);

endmodule

// File: rtl/sync_phase_tracker.sv
// Local transducer period counter realigned by upstream sync pulses, with
// phase-error measurement and a lock/watchdog FSM.
//   clk, rst     : clock, asynchronous active-high reset
//   sync_pulse   : one-cycle pulse per received sync edge
//   phase_count  : period counter 0..PERIOD_CYCLES-1
//   period_start : high while phase_count == 0
//   locked       : high in LOCKED state
//   sync_error   : one-cycle pulse, out-of-tolerance sync while LOCKED
//   sync_lost    : one-cycle pulse, watchdog expiry in ACQUIRE/LOCKED
//   last_error   : signed phase error measured at the most recent sync
module sync_phase_tracker
   import sync_pkg::*;
#(
   parameter  int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
   parameter  int SYNC_OFFSET   = 3,
   parameter  int TOLERANCE     = 2,
   parameter  int LOCK_COUNT    = 4,
   parameter  int SYNC_TIMEOUT  = 2500,
   localparam int CNT_W         = cnt_width(PERIOD_CYCLES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sync_pulse,
   output logic [CNT_W-1:0]        phase_count,
   output logic                    period_start,
   output logic                    locked,
   output logic                    sync_error,
   output logic                    sync_lost,
   output logic signed [CNT_W:0]   last_error
);

   // Counter value a perfectly aligned sync should land on: one cycle before
   // the reload value, since the reload takes effect the cycle after.
   localparam int EXPECTED = (SYNC_OFFSET - 1 + PERIOD_CYCLES) % PERIOD_CYCLES;
   localparam int HALF     = PERIOD_CYCLES / 2;
   localparam int GOOD_W   = cnt_width(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]  LAST_PHASE   = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  OFFSET_PHASE = CNT_W'(SYNC_OFFSET);
   localparam logic [GOOD_W-1:0] LOCK_LAST    = GOOD_W'(LOCK_COUNT - 1);

   sync_lock_state_t        state_r, state_nx;
   logic [GOOD_W-1:0]       good_r, good_nx;
   logic                    error_nx, lost_nx;
   logic                    expired_s, arm_s, good_s;
   logic signed [CNT_W:0]   err_s;
   int                      raw_err, abs_err;

   // Free-running period counter; every sync reloads the offset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_count <= '0;
      end else if (sync_pulse) begin
         phase_count <= OFFSET_PHASE;
      end else if (phase_count == LAST_PHASE) begin
         phase_count <= '0;
      end else begin
         phase_count <= phase_count + CNT_W'(1);
      end
   end

   assign period_start = (phase_count == '0);

   // Phase error folded into the shortest signed distance around the period.
   always_comb begin
      raw_err = int'(phase_count) - EXPECTED;
      if (raw_err > HALF) begin
         raw_err = raw_err - PERIOD_CYCLES;
      end else if (raw_err < -HALF) begin
         raw_err = raw_err + PERIOD_CYCLES;
      end else begin
         raw_err = raw_err;
      end
      abs_err = (raw_err < 0) ? -raw_err : raw_err;
      good_s  = (abs_err <= TOLERANCE);
      err_s   = raw_err[CNT_W:0];
   end

   assign arm_s = (state_r == ACQUIRE) || (state_r == LOCKED);

   sync_watchdog #(
      .TIMEOUT (SYNC_TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .kick    (sync_pulse),
      .arm     (arm_s),
      .expired (expired_s)
   );

   // Lock FSM state, good-sync count and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= UNLOCKED;
         good_r     <= '0;
         locked     <= 1'b0;
         sync_error <= 1'b0;
         sync_lost  <= 1'b0;
         last_error <= '0;
      end else begin
         state_r    <= state_nx;
         good_r     <= good_nx;
         locked     <= (state_nx == LOCKED);
         sync_error <= error_nx;
         sync_lost  <= lost_nx;
         if (sync_pulse) begin
            last_error <= err_s;
         end else begin
            last_error <= last_error;
         end
      end
   end

   // Next-state logic; a sync always takes priority over watchdog expiry.
   always_comb begin
      state_nx = state_r;
      good_nx  = good_r;
      error_nx = 1'b0;
      lost_nx  = 1'b0;
      case (state_r)
         UNLOCKED: begin
            // First sync only starts acquisition; its error is not judged.
            if (sync_pulse) begin
               state_nx = ACQUIRE;
               good_nx  = '0;
            end else begin
               state_nx = UNLOCKED;
            end
         end
         ACQUIRE: begin
            if (sync_pulse) begin
               if (good_s) begin
                  if (good_r == LOCK_LAST) begin
                     state_nx = LOCKED;
                     good_nx  = '0;
                  end else begin
                     good_nx  = good_r + GOOD_W'(1);
                  end
               end else begin
                  good_nx = '0;
               end
            end else if (expired_s) begin
               state_nx = UNLOCKED;
               good_nx  = '0;
               lost_nx  = 1'b1;
            end else begin
               state_nx = ACQUIRE;
            end
         end
         LOCKED: begin
            if (sync_pulse) begin
               if (good_s) begin
                  state_nx = LOCKED;
               end else begin
                  state_nx = ACQUIRE;
                  good_nx  = '0;
                  error_nx = 1'b1;
               end
            end else if (expired_s) begin
               state_nx = UNLOCKED;
               good_nx  = '0;
               lost_nx  = 1'b1;
            end else begin
               state_nx = LOCKED;
            end
         end
         default: begin
            state_nx = UNLOCKED;
            good_nx  = '0;
         end
      endcase
   end

endmodule
